// File: rtl/mc_pkg.sv
// Shared types and encodings for the SimpleARM multicycle controller.
// Instr port carries Instr[31:12]; bit indices below are relative to that slice.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_SHIFT = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // flags is {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Holds the NZCV flag register and evaluates the condition field against it.
module cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_write,
  output logic       cond_ex,
  output logic       stored_carry
);

  logic [3:0] flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (flag_write) begin
      flags <= alu_flags;
    end
  end

  // Only the held flags participate; live ALU flags belong to the current op.
  assign cond_ex      = cond_eval(cond, flags);
  assign stored_carry = flags[1];

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the SimpleARM core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath.
module mc_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        linkSelect,
  output logic        storedCarry,
  output logic [3:0]  state_o
);

  state_t state, state_next;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic       u_bit;
  logic       l_bit;
  logic       link_bit;
  logic [3:0] rd;
  logic       rd_is_pc;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign i_bit     = Instr[13];
  assign opcode    = Instr[12:9];
  assign link_bit  = Instr[12];
  assign u_bit     = Instr[11];
  assign s_bit     = Instr[8];
  assign l_bit     = Instr[8];
  assign rd        = Instr[3:0];
  assign rd_is_pc  = (rd == 4'hF);
  assign unused_rn = ^Instr[7:4];

  logic cond_ex;
  logic flag_write;
  logic pc_write_s;
  logic mem_write_s;
  logic ir_write_s;
  logic reg_write_s;

  cond_unit u_cond (
    .clk          (clk),
    .reset        (reset),
    .cond         (cond),
    .alu_flags    (ALUFlags),
    .flag_write   (flag_write),
    .cond_ex      (cond_ex),
    .stored_carry (storedCarry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    flag_write  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_SHIFT;
    ALUControl  = ALU_ADD;
    ImmSrc      = IMM_DP;
    RegSrc      = 2'b00;
    linkSelect  = 1'b0;

    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        pc_write_s = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURES;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        // PC+8 is formed here so R15 reads see the architectural value.
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (!cond_ex) begin
          state_next = S_FETCH;
        end else begin
          case (op)
            OP_DP:   state_next = i_bit ? S_EXECI : S_EXECR;
            OP_MEM:  state_next = S_MEMADR;
            OP_BR:   state_next = S_BRANCH;
            default: state_next = S_FETCH;
          endcase
        end
      end

      S_EXECR, S_EXECI: begin
        ALUControl = opcode;
        ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_SHIFT;
        flag_write = s_bit;
        // TST/TEQ/CMP/CMN only set flags and have no destination.
        state_next = (opcode[3:2] == 2'b10) ? S_FETCH : S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc   = RES_ALUOUT;
        reg_write_s = 1'b1;
        pc_write_s  = rd_is_pc;
        state_next  = S_FETCH;
      end

      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_MEM;
        ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        state_next = l_bit ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
        pc_write_s  = rd_is_pc;
        state_next  = S_FETCH;
      end

      S_MEMWR: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        RegSrc      = 2'b10;
        state_next  = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b0;
        RegSrc      = 2'b01;
        ALUSrcB     = SRCB_IMM;
        ImmSrc      = IMM_BR;
        ALUControl  = ALU_ADD;
        ResultSrc   = RES_ALURES;
        pc_write_s  = 1'b1;
        linkSelect  = link_bit;
        reg_write_s = link_bit;
        state_next  = S_FETCH;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Reset lands in FETCH, whose Moore enables are active; mask them while
  // reset is held so nothing is written during or right after abort.
  assign PCWrite  = pc_write_s  & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign RegWrite = reg_write_s & ~reset;

  assign state_o = state;

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: one row per clock cycle, plus a
// hand-written reset-abort sequence.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        linkSelect;
  logic        storedCarry;
  logic [3:0]  state_o;

  mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .Instr       (Instr),
    .ALUFlags    (ALUFlags),
    .PCWrite     (PCWrite),
    .AdrSrc      (AdrSrc),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .ResultSrc   (ResultSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUControl  (ALUControl),
    .ImmSrc      (ImmSrc),
    .RegSrc      (RegSrc),
    .linkSelect  (linkSelect),
    .storedCarry (storedCarry),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] S_F  = 4'd0;
  localparam logic [3:0] S_D  = 4'd1;
  localparam logic [3:0] S_XR = 4'd2;
  localparam logic [3:0] S_XI = 4'd3;
  localparam logic [3:0] S_WB = 4'd4;
  localparam logic [3:0] S_MA = 4'd5;
  localparam logic [3:0] S_MR = 4'd6;
  localparam logic [3:0] S_MB = 4'd7;
  localparam logic [3:0] S_MW = 4'd8;
  localparam logic [3:0] S_BR = 4'd9;
  localparam logic [3:0] G    = 4'b1001;

  // en = {PCWrite, RegWrite, MemWrite, IRWrite}
  // cm = care mask {ALUSrcA, AdrSrc, ResultSrc, ALUControl, ALUSrcB, linkSelect}
  typedef struct {
    logic [19:0] instr;
    logic [3:0]  flg;
    logic [3:0]  st;
    logic [3:0]  en;
    logic        sc;
    logic [5:0]  cm;
    logic        srca;
    logic        adr;
    logic [1:0]  rs;
    logic [3:0]  aluc;
    logic [1:0]  srcb;
    logic        lk;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_pass;

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                     input logic [5:0] f, input logic [3:0] rn,
                                     input logic [3:0] rd);
    return {c, op, f, rn, rd};
  endfunction

  task automatic v(input logic [19:0] ins, input logic [3:0] flg, input logic [3:0] st,
                   input logic [3:0] en, input logic sc, input logic [5:0] cm,
                   input logic srca, input logic adr, input logic [1:0] rs,
                   input logic [3:0] aluc, input logic [1:0] srcb, input logic lk);
    vec_t r;
    r.instr = ins; r.flg = flg; r.st = st; r.en = en; r.sc = sc; r.cm = cm;
    r.srca = srca; r.adr = adr; r.rs = rs; r.aluc = aluc; r.srcb = srcb; r.lk = lk;
    tbl.push_back(r);
  endtask

  task automatic fr(input logic [19:0] ins, input logic sc);
    v(ins, G, S_F, 4'b1001, sc, 6'b111110, 1'b1, 1'b0, 2'b10, 4'b0100, 2'b10, 1'b0);
  endtask

  task automatic dr(input logic [19:0] ins, input logic sc);
    v(ins, G, S_D, 4'b0000, sc, 6'b100010, 1'b1, 1'b0, 2'b00, 4'b0000, 2'b10, 1'b0);
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [19:0] adds, cmp, beq, movpc, ldr, str, bl, nop, bnv, bhi, blt, bcs;

  initial begin
    n_chk = 0;
    n_pass = 0;
    adds  = mk(4'hE, 2'b00, 6'b001001, 4'd3, 4'd1);
    cmp   = mk(4'hE, 2'b00, 6'b010101, 4'd1, 4'd0);
    beq   = mk(4'h0, 2'b10, 6'b000000, 4'd0, 4'd0);
    movpc = mk(4'hE, 2'b00, 6'b111010, 4'd0, 4'hF);
    ldr   = mk(4'hE, 2'b01, 6'b011001, 4'd2, 4'hF);
    str   = mk(4'hE, 2'b01, 6'b010000, 4'd2, 4'd3);
    bl    = mk(4'hE, 2'b10, 6'b010000, 4'd0, 4'd0);
    nop   = mk(4'hE, 2'b11, 6'b000000, 4'd0, 4'd0);
    bnv   = mk(4'hF, 2'b10, 6'b000000, 4'd0, 4'd0);
    bhi   = mk(4'h8, 2'b10, 6'b000000, 4'd0, 4'd0);
    blt   = mk(4'hB, 2'b10, 6'b000000, 4'd0, 4'd0);
    bcs   = mk(4'h2, 2'b10, 6'b000000, 4'd0, 4'd0);

    // ADDS R1: flags <- 0110 in EXECR, carry visible in ALUWB
    fr(adds, 0); dr(adds, 0);
    v(adds, 4'b0110, S_XR, 4'b0000, 0, 6'b000110, 0, 0, 2'b00, 4'b0100, 2'b00, 0);
    v(adds, G, S_WB, 4'b0100, 1, 6'b001000, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    // CMP setting Z=1, C=0
    fr(cmp, 1); dr(cmp, 1);
    v(cmp, 4'b0100, S_XR, 4'b0000, 1, 6'b000110, 0, 0, 2'b00, 4'b1010, 2'b00, 0);
    // BEQ taken
    fr(beq, 0); dr(beq, 0);
    v(beq, G, S_BR, 4'b1000, 0, 6'b101111, 0, 0, 2'b10, 4'b0100, 2'b01, 0);
    // CMP setting Z=0, C=1, then BEQ annulled
    fr(cmp, 0); dr(cmp, 0);
    v(cmp, 4'b0010, S_XR, 4'b0000, 0, 6'b000110, 0, 0, 2'b00, 4'b1010, 2'b00, 0);
    fr(beq, 1); dr(beq, 1);
    // MOV PC, #imm without S: flags must hold despite ALUFlags=0000
    fr(movpc, 1); dr(movpc, 1);
    v(movpc, 4'b0000, S_XI, 4'b0000, 1, 6'b000110, 0, 0, 2'b00, 4'b1101, 2'b01, 0);
    v(movpc, G, S_WB, 4'b1100, 1, 6'b001000, 0, 0, 2'b00, 4'b0000, 2'b00, 0);
    // LDR PC
    fr(ldr, 1); dr(ldr, 1);
    v(ldr, G, S_MA, 4'b0000, 1, 6'b000110, 0, 0, 2'b00, 4'b0100, 2'b01, 0);
    v(ldr, G, S_MR, 4'b0000, 1, 6'b010000, 0, 1, 2'b00, 4'b0000, 2'b00, 0);
    v(ldr, G, S_MB, 4'b1100, 1, 6'b001000, 0, 0, 2'b01, 4'b0000, 2'b00, 0);
    // STR with U=0
    fr(str, 1); dr(str, 1);
    v(str, G, S_MA, 4'b0000, 1, 6'b000110, 0, 0, 2'b00, 4'b0010, 2'b01, 0);
    v(str, G, S_MW, 4'b0010, 1, 6'b010000, 0, 1, 2'b00, 4'b0000, 2'b00, 0);
    // BL
    fr(bl, 1); dr(bl, 1);
    v(bl, G, S_BR, 4'b1100, 1, 6'b101111, 0, 0, 2'b10, 4'b0100, 2'b01, 1);
    // cond never, HI taken (C=1,Z=0), LT annulled (N==V)
    fr(bnv, 1); dr(bnv, 1);
    fr(bhi, 1); dr(bhi, 1);
    v(bhi, G, S_BR, 4'b1000, 1, 6'b101111, 0, 0, 2'b10, 4'b0100, 2'b01, 0);
    fr(blt, 1); dr(blt, 1);
    // op=11 NOP
    fr(nop, 1); dr(nop, 1);

    reset = 1'b1;
    Instr = 20'h0;
    ALUFlags = 4'b0000;
    @(negedge clk);
    #1;
    chk("rst state", 32'(state_o), 32'(S_F));
    chk("rst PCWrite", 32'(PCWrite), 0);
    chk("rst IRWrite", 32'(IRWrite), 0);
    chk("rst RegWrite", 32'(RegWrite), 0);
    chk("rst MemWrite", 32'(MemWrite), 0);
    chk("rst carry", 32'(storedCarry), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      Instr = tbl[i].instr;
      ALUFlags = tbl[i].flg;
      #1;
      chk($sformatf("r%0d state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("r%0d enables", i), 32'({PCWrite, RegWrite, MemWrite, IRWrite}), 32'(tbl[i].en));
      chk($sformatf("r%0d storedCarry", i), 32'(storedCarry), 32'(tbl[i].sc));
      if (tbl[i].cm[5]) chk($sformatf("r%0d ALUSrcA", i), 32'(ALUSrcA), 32'(tbl[i].srca));
      if (tbl[i].cm[4]) chk($sformatf("r%0d AdrSrc", i), 32'(AdrSrc), 32'(tbl[i].adr));
      if (tbl[i].cm[3]) chk($sformatf("r%0d ResultSrc", i), 32'(ResultSrc), 32'(tbl[i].rs));
      if (tbl[i].cm[2]) chk($sformatf("r%0d ALUControl", i), 32'(ALUControl), 32'(tbl[i].aluc));
      if (tbl[i].cm[1]) chk($sformatf("r%0d ALUSrcB", i), 32'(ALUSrcB), 32'(tbl[i].srcb));
      if (tbl[i].cm[0]) chk($sformatf("r%0d linkSelect", i), 32'(linkSelect), 32'(tbl[i].lk));
      step();
    end

    // reset while in MEMWR: write strobe drops at once, flags cleared
    Instr = str;
    ALUFlags = G;
    #1;
    chk("ab fetch", 32'(state_o), 32'(S_F));
    step(); step(); step();
    #1;
    chk("ab memwr state", 32'(state_o), 32'(S_MW));
    chk("ab memwr strobe", 32'(MemWrite), 1);
    reset = 1'b1;
    #1;
    chk("ab MemWrite", 32'(MemWrite), 0);
    chk("ab state", 32'(state_o), 32'(S_F));
    chk("ab PCWrite", 32'(PCWrite), 0);
    chk("ab IRWrite", 32'(IRWrite), 0);
    chk("ab carry", 32'(storedCarry), 0);
    step();
    reset = 1'b0;
    Instr = bcs;
    #1;
    chk("ab rel state", 32'(state_o), 32'(S_F));
    chk("ab rel IRWrite", 32'(IRWrite), 1);
    step();
    #1;
    chk("ab bcs decode", 32'(state_o), 32'(S_D));
    step();
    #1;
    chk("ab bcs annulled", 32'(state_o), 32'(S_F));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
